// File: rtl/zint_trig.sv
// zint_trig: raster-driven interrupt trigger scheduler (frame, line and DMA-end pulses).
// Optional build macro ZTRIG_READBACK_EN adds the rd_addr/rd_data register readback port.
module zint_trig #(
    parameter int HW = 9,
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          line_start,
    input  logic          frame_start,
    input  logic [HW-1:0] hcnt,
    input  logic          dma_busy,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [7:0]    wr_data,
`ifdef ZTRIG_READBACK_EN
    input  logic [2:0]    rd_addr,
    output logic [7:0]    rd_data,
`endif
    output logic          int_start_frm,
    output logic          int_start_lin,
    output logic          int_start_dma,
    output logic [7:0]    intmask
);

    logic [7:0]    hpos;
    logic [8:0]    vpos;
    logic [7:0]    linper;
    logic [7:0]    mask_r;
    logic [VW-1:0] vcnt;
    logic [7:0]    lcnt;
    logic          armed;
    logic          match;
    logic          match_r;
    logic          frm_fire;
    logic          dma_busy_r;

    assign intmask = mask_r;

    // CPU-visible configuration registers
    always_ff @(posedge clk) begin
        if (!res_n) begin
            hpos   <= 8'h00;
            vpos   <= 9'h000;
            linper <= 8'h00;
            mask_r <= 8'h01;
        end else if (wr_en) begin
            case (wr_addr)
                3'd0:    hpos      <= wr_data;
                3'd1:    vpos[7:0] <= wr_data;
                3'd2:    vpos[8]   <= wr_data[0];
                3'd3:    mask_r    <= wr_data;
                3'd4:    linper    <= wr_data;
                default: ;
            endcase
        end
    end

    // Line counter saturates so an out-of-range VPOS can never alias onto a real line
    always_ff @(posedge clk) begin
        if (!res_n) begin
            vcnt <= '0;
        end else if (frame_start) begin
            vcnt <= '0;
        end else if (line_start && (vcnt != '1)) begin
            vcnt <= vcnt + VW'(1);
        end
    end

    // hcnt is compared at 2-tick granularity; shifting keeps the whole input in use
    assign match    = (vcnt == VW'(vpos)) && ((hcnt >> 1) == HW'(hpos));
    assign frm_fire = armed && match && !match_r && mask_r[0];

    // Frame INT: rising edge of the position match, once per armed frame
    always_ff @(posedge clk) begin
        if (!res_n) begin
            armed         <= 1'b0;
            match_r       <= 1'b0;
            int_start_frm <= 1'b0;
        end else begin
            match_r       <= match;
            int_start_frm <= frm_fire;
            if (frame_start) begin
                armed <= 1'b1;
            end else if (frm_fire) begin
                armed <= 1'b0;
            end
        end
    end

    // Line INT: down-counter reloaded from LINPER, phase-locked to line 0
    always_ff @(posedge clk) begin
        if (!res_n) begin
            lcnt          <= 8'h00;
            int_start_lin <= 1'b0;
        end else begin
            int_start_lin <= 1'b0;
            if (line_start) begin
                if (frame_start || (lcnt == 8'h00)) begin
                    int_start_lin <= mask_r[1];
                    lcnt          <= linper;
                end else begin
                    lcnt <= lcnt - 8'd1;
                end
            end
        end
    end

    // DMA-end INT: falling edge of dma_busy; a masked edge is simply dropped
    always_ff @(posedge clk) begin
        if (!res_n) begin
            dma_busy_r    <= 1'b0;
            int_start_dma <= 1'b0;
        end else begin
            dma_busy_r    <= dma_busy;
            int_start_dma <= dma_busy_r && !dma_busy && mask_r[2];
        end
    end

`ifdef ZTRIG_READBACK_EN
    logic [8:0] vcnt9;
    assign vcnt9 = 9'(vcnt);

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            3'd0:    rd_data = hpos;
            3'd1:    rd_data = vpos[7:0];
            3'd2:    rd_data = {7'b0, vpos[8]};
            3'd3:    rd_data = mask_r;
            3'd4:    rd_data = linper;
            3'd5:    rd_data = vcnt9[7:0];
            3'd6:    rd_data = {7'b0, vcnt9[8]};
            default: rd_data = lcnt;
        endcase
    end
`endif

endmodule

// File: doc/zint_trig.md
Name: zint_trig

Overview:
- Interrupt trigger scheduler feeding the Z80 interrupt latch block.
- Holds the CPU-programmed interrupt configuration: frame-INT raster position, line-INT period and the interrupt mask.
- Tracks the raster and generates single-clock int_start_frm / int_start_lin / int_start_dma pulses, plus the intmask vector consumed by the latch.

Parameters:
- HW, 9, width of horizontal counter input hcnt.
- VW, 9, width of internal line counter and frame-INT vertical position.

Ports:
- clk  in  1  system clock.
- res_n  in  1  reset, synchronous, active-low.
- line_start  in  1  one-clk pulse at start of every video line.
- frame_start  in  1  one-clk pulse at start of line 0; always coincident with a line_start.
- hcnt  in  HW  current horizontal raster position, may hold a value for several clks.
- dma_busy  in  1  DMA engine active level.
- wr_en  in  1  register write strobe, one clk.
- wr_addr  in  3  register select.
- wr_data  in  8  write data.
- int_start_frm  out  1  frame-INT trigger pulse.
- int_start_lin  out  1  line-INT trigger pulse.
- int_start_dma  out  1  DMA-end-INT trigger pulse.
- intmask  out  8  interrupt enable mask; bit0 frm, bit1 lin, bit2 dma, bits7:3 stored but unused.

Behaviour:
Reset:
- res_n low at a clk edge clears: all pulse outputs, vcnt, lcnt, the armed flag, the hcnt match history and dma_busy_r.
- Register reset values: HPOS=0, VPOS=0, LINPER=0, INTMASK=8'h01.

Registers (write on clk edge with wr_en=1; new value used by compare logic from the next clk):
- addr 0 HPOS[7:0]; compared against hcnt[HW-1:1], i.e. 2-tick granularity.
- addr 1 VPOS[7:0].
- addr 2 VPOS[8] (wr_data bit0 only).
- addr 3 INTMASK[7:0].
- addr 4 LINPER[7:0].
- addr 5-7: writes ignored.

Line counter vcnt (VW bits):
- frame_start: vcnt <= 0.
- Otherwise line_start: vcnt <= vcnt+1, saturating at all-ones (no wrap).

Frame INT:
- Armed flag set by frame_start.
- match = (vcnt==VPOS) && (hcnt[HW-1:1]==HPOS). match_r is match delayed one clk.
- Fire condition: armed && match && !match_r && INTMASK[0].
- On fire: int_start_frm=1 for exactly one clk, registered (asserted the clk after the condition); armed cleared.
- At most one frame INT per frame. VPOS beyond the last line: no frame INT that frame.
- frame_start and fire in the same clk: re-arm wins, and the fire is still emitted.

Line INT:
- lcnt[7:0] down-counter, evaluated on each line_start.
- If frame_start or lcnt==0: pulse int_start_lin (if INTMASK[1]) and lcnt <= LINPER.
- Else lcnt <= lcnt-1.
- LINPER=0 gives an INT every line; LINPER=N gives one every N+1 lines, phase-locked to line 0.
- A LINPER write takes effect at the next reload, not mid-count.

DMA INT:
- dma_busy_r is dma_busy delayed one clk.
- Falling edge (dma_busy_r && !dma_busy) with INTMASK[2] set gives a one-clk int_start_dma, registered.
- A masked edge is lost, not deferred.

General:
- All three outputs are independent and may assert in the same clk.
- Clearing a mask bit never truncates a pulse already registered.
- Reset mid-frame: armed=0, so no frame INT until the next frame_start.
- Reset mid-DMA: no spurious DMA pulse, because dma_busy_r resets to 0.

Optional Feature:
- Macro ZTRIG_READBACK_EN.
- Defined: adds ports rd_addr in 3 and rd_data out 8.
- rd_data is combinational from rd_addr:
  - 0 HPOS
  - 1 VPOS[7:0]
  - 2 {7'b0, VPOS[8]}
  - 3 INTMASK
  - 4 LINPER
  - 5 vcnt[7:0]
  - 6 {7'b0, vcnt[8]}
  - 7 lcnt
- Undefined: those ports are absent; no readback logic.

Test Plan:
- Reset values: res_n low 2 clks then high, no writes -> intmask=8'h01, all pulses 0, and the first frame INT fires at line 0, hcnt=0/1 boundary.
- Frame INT position: HPOS=0x20, VPOS=0x105, run 320-line frame with hcnt sweeping 0..447 holding each value 2 clks -> exactly one int_start_frm, 1 clk wide, the clk after line 261 where hcnt first reaches 0x40. Second frame -> again exactly one.
- Out-of-range VPOS: VPOS=0x1F0, 320-line frame -> zero int_start_frm.
- Line period: INTMASK=8'h02, LINPER=3 -> int_start_lin on lines 0,4,8,...,316 (80 pulses per frame).
- Line period rewrite: LINPER written to 0 at line 10 -> pulses resume every line from line 12 onward.
- DMA and masking: dma_busy high 50 clks then low with INTMASK=8'h04 -> one int_start_dma 1 clk after the fall. Repeat with INTMASK=0 -> no pulse. Assert res_n low while dma_busy=1, then release with dma_busy=0 -> no pulse.
- Simultaneous events: frame INT at VPOS=0/HPOS=0, LINPER=0, DMA fall aligned to line 0 start, INTMASK=8'h07 -> frm, lin and dma pulses each emitted once, none dropped.
